fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter DEPTH, default 4, instruction queue entries and maximum in-flight requests; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 Port clk input 1: single clock, all state on rising edge.
REQ-005 Port rst_n input 1: reset, asynchronous and active-low.
REQ-006 Port imem_req_valid output 1: fetch request valid.
REQ-007 Port imem_req_ready input 1: memory accepts request this cycle.
REQ-008 Port imem_req_addr output XLEN: fetch address, word aligned.
REQ-009 Port imem_rsp_valid input 1: in-order instruction return.
REQ-010 Port imem_rsp_data input 32: returned instruction word.
REQ-011 Port redirect_valid input 1: branch/jump taken, flush and refetch.
REQ-012 Port redirect_pc input XLEN: new fetch address.
REQ-013 Port dec_valid output 1: decode-stage instruction valid.
REQ-014 Port dec_ready input 1: decode stage consumes this cycle.
REQ-015 Port dec_instr output 32: head instruction; 32'h0000_0013 (NOP) when dec_valid=0.
REQ-016 Port dec_pc output XLEN: PC of head instruction; 0 when dec_valid=0.

Function
REQ-017 Request handshake: fire = imem_req_valid & imem_req_ready; fetch PC advances by 4 on fire only, wraps modulo 2^XLEN.
REQ-018 imem_req_valid = !redirect_valid & (queue_count + outstanding < DEPTH); combinational from state, addr held stable while valid & !ready.
REQ-019 outstanding increments on fire, decrements on imem_rsp_valid; both same cycle leaves it unchanged.
REQ-020 Live response pushed into queue with its PC (from a DEPTH-entry in-flight PC FIFO); visible on dec_* the cycle after imem_rsp_valid (1-cycle latency).
REQ-021 Pop on dec_valid & dec_ready; push and pop same cycle legal at full and empty; no overflow possible by REQ-018 credit rule.
REQ-022 Redirect: queue flushed, fetch PC := {redirect_pc[XLEN-1:2],2'b00} next cycle, drop_count := outstanding (including any response arriving that cycle, which is discarded).
REQ-023 While drop_count>0, each imem_rsp_valid is discarded and decrements drop_count and outstanding; nothing pushed.
REQ-024 Redirect beats pop and push in the same cycle: dec_valid=0 next cycle.
REQ-025 Redirect during back-to-back redirects: latest redirect_pc wins; drop_count recomputed from current outstanding.
REQ-026 imem_rsp_valid with outstanding=0 ignored; flagged by a simulation assertion.
REQ-027 States IDLE-free: behaviour fully defined by fetch PC, queue pointers/count, outstanding, drop_count; no separate FSM beyond these counters.

Reset
REQ-028 During rst_n=0: imem_req_valid=0, dec_valid=0, dec_instr=32'h13, dec_pc=0, imem_req_addr=RESET_PC, queue empty, outstanding=0, drop_count=0.
REQ-029 First cycle after rst_n rises: imem_req_valid=1, imem_req_addr=RESET_PC.
REQ-030 Reset mid-operation discards all queued and in-flight state; late responses after reset ignored per REQ-026.

Structure
REQ-031 Shared package rv_pkg holds NOP_INSTR (32'h0000_0013) and XLEN default; reused by decode and hazard logic.
REQ-032 One sub-module, sync_fifo (parametrised width/depth, count output, flush input), instantiated twice: instruction+PC queue and in-flight PC FIFO.

Verification
REQ-033 Reset, imem_req_ready=1, zero-latency responses, dec_ready=1 -> dec_pc sequence 0,4,8,12; dec_instr equals returned data.
REQ-034 dec_ready=0, memory always ready -> exactly 4 requests issued (addr 0..12), then imem_req_valid=0 until a pop.
REQ-035 2 requests in flight (0x0,0x4), redirect_pc=0x103 -> next addr 0x100; both stale responses dropped; first dec_pc=0x100.
REQ-036 Redirect same cycle as dec pop and rsp -> dec_valid=0 next cycle, dec_instr=32'h13, outstanding reduced by 1.
REQ-037 imem_req_ready low 3 cycles -> imem_req_addr constant 0x8, no PC advance; rst_n pulsed mid-stream -> outputs at REQ-028 values immediately, asynchronously.
REQ-038 Fetch PC 32'hFFFF_FFFC fires -> next imem_req_addr 32'h0000_0000.

Source files
------------

// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared RISC-V front-end definitions. The fetch queue uses them, and so do the
// decode and hazard blocks.
//   XLEN_DEFAULT : default address / PC width
//   NOP_INSTR    : canonical NOP (addi x0, x0, 0). Decode sees it whenever no
//                  valid instruction is presented.
// -----------------------------------------------------------------------------
package rv_pkg;
    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a show-ahead head output, an occupancy count and a
// synchronous flush. DEPTH must be a power of two (at least 2) so that the
// pointers wrap naturally.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_flush       : empties the FIFO next edge (wins over push/pop)
//   i_push        : write i_push_data (accepted when not full, or when full
//                   and popping in the same cycle)
//   i_pop         : drop the head entry (ignored when empty)
//   o_head_data   : current head entry (undefined when o_count == 0)
//   o_count       : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head_data,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int              AW         = $clog2(DEPTH);
    localparam int              CW         = AW + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;
endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch front end. It issues word-aligned fetch requests, keeps the
// PCs of in-flight requests, pairs in-order responses with those PCs and queues
// the results for decode. A redirect flushes the queue, restarts fetch at the
// new PC and discards the responses still owed for the old stream.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr           : fetch request handshake
//   imem_rsp_valid/data                 : in-order instruction return
//   redirect_valid/pc                   : taken branch/jump, refetch from pc
//   dec_valid/ready, dec_instr, dec_pc  : head of the instruction queue
//                                         (NOP and PC 0 when dec_valid = 0)
// -----------------------------------------------------------------------------
module fetch_queue
    import rv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [XLEN-1:0] dec_pc
);
    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam int            QW        = 32 + XLEN;
    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_count;

    logic [CW-1:0]   w_q_count;
    logic [CW-1:0]   w_if_count;
    logic [QW-1:0]   w_q_head;
    logic [XLEN-1:0] w_if_head;
    logic [CW:0]     w_credit_sum;
    logic            w_req_valid;
    logic            w_fire;
    logic            w_rsp_live;
    logic            w_rsp_drop;
    logic            w_rsp_push;
    logic            w_dec_valid;
    logic            w_dec_pop;
    logic [CW-1:0]   w_outstanding_next;
    logic [XLEN-1:0] w_redirect_aligned;

    // Queued entries plus in-flight requests never exceed DEPTH. That credit
    // rule is what keeps the instruction queue from overflowing.
    assign w_credit_sum = {1'b0, w_q_count} + {1'b0, r_outstanding};

    // rst_n gates the request directly. The state is already at its reset
    // values while rst_n is low, and that alone would still allow a request.
    assign w_req_valid = rst_n & ~redirect_valid & (w_credit_sum < DEPTH_SUM);
    assign w_fire      = w_req_valid & imem_req_ready;

    // A response with nothing outstanding cannot belong to any request
    // (e.g. it arrives late after a reset) and is ignored.
    assign w_rsp_live = imem_rsp_valid & (r_outstanding != '0);
    // Responses for the pre-redirect stream are dropped. This includes one
    // that arrives in the same cycle as the redirect itself.
    assign w_rsp_drop = w_rsp_live & (redirect_valid | (r_drop_count != '0));
    assign w_rsp_push = w_rsp_live & ~w_rsp_drop & (w_if_count != '0);

    assign w_dec_valid = (w_q_count != '0);
    // A redirect flushes the queue, so a pop in that cycle is moot.
    assign w_dec_pop   = w_dec_valid & dec_ready & ~redirect_valid;

    assign w_outstanding_next = r_outstanding + CW'(w_fire) - CW'(w_rsp_live);
    assign w_redirect_aligned = redirect_pc & ~XLEN'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_count  <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (redirect_valid) begin
                r_fetch_pc   <= w_redirect_aligned;
                // Every request still outstanding after this cycle belongs to
                // the old stream. No request fires during a redirect.
                r_drop_count <= w_outstanding_next;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (w_rsp_live && (r_drop_count != '0)) begin
                    r_drop_count <= r_drop_count - CW'(1);
                end
            end
        end
    end

    // Instruction + PC queue presented to decode.
    sync_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (redirect_valid),
        .i_push      (w_rsp_push),
        .i_push_data ({imem_rsp_data, w_if_head}),
        .i_pop       (w_dec_pop),
        .o_head_data (w_q_head),
        .o_count     (w_q_count)
    );

    // PCs of requests whose responses will be kept. On a redirect it is
    // flushed, because the surviving responses are discarded by drop_count
    // and never need a PC.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_inflight_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (redirect_valid),
        .i_push      (w_fire),
        .i_push_data (r_fetch_pc),
        .i_pop       (w_rsp_push),
        .o_head_data (w_if_head),
        .o_count     (w_if_count)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign dec_valid      = w_dec_valid;
    assign dec_instr      = w_dec_valid ? w_q_head[QW-1:XLEN] : NOP_INSTR;
    assign dec_pc         = w_dec_valid ? w_q_head[XLEN-1:0]  : '0;

    // The memory must never return more responses than were requested.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (r_outstanding == '0)));
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    int errors = 0;
    int checks = 0;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Memory owes responses for every fired request, in order. Requests
    // issued before a redirect are marked stale; their data never reaches decode.
    typedef struct {
        logic [31:0] addr;
        logic        stale;
    } inflight_t;

    inflight_t   m_inflight[$];
    logic [31:0] m_q[$];
    logic [31:0] m_fetch_pc;

    logic        exp_req_valid, obs_req_valid;
    logic [31:0] exp_addr, obs_addr;
    logic        exp_dec_valid, obs_dec_valid;
    logic [31:0] exp_dec_pc, obs_dec_pc;
    logic [31:0] exp_dec_instr, obs_dec_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic void model_reset();
        m_inflight.delete();
        m_q.delete();
        m_fetch_pc = RPC;
    endfunction

    // One clock cycle: drive inputs at the negedge, sample outputs 1 time unit
    // later, advance the model at the posedge, then return at the next negedge.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy,
                        input logic drdy, input logic rsp_en);
        logic      do_rsp;
        inflight_t ent;
        do_rsp         = rsp_en && (m_inflight.size() > 0);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        dec_ready      = drdy;
        imem_rsp_valid = do_rsp;
        imem_rsp_data  = do_rsp ? mem_word(m_inflight[0].addr) : 32'h0;
        #1;
        exp_req_valid = !redir && ((m_q.size() + m_inflight.size()) < DEPTH);
        exp_addr      = m_fetch_pc;
        exp_dec_valid = (m_q.size() > 0);
        exp_dec_pc    = exp_dec_valid ? m_q[0] : 32'h0;
        exp_dec_instr = exp_dec_valid ? mem_word(m_q[0]) : NOP;
        obs_req_valid = imem_req_valid;
        obs_addr      = imem_req_addr;
        obs_dec_valid = dec_valid;
        obs_dec_pc    = dec_pc;
        obs_dec_instr = dec_instr;
        if (obs_dec_valid && drdy && !redir)
            $display("pop  pc=%08h instr=%08h", obs_dec_pc, obs_dec_instr);
        @(posedge clk);
        ent.addr  = 32'h0;
        ent.stale = 1'b1;
        if (do_rsp) ent = m_inflight.pop_front();
        if (redir) begin
            m_q.delete();
            foreach (m_inflight[i]) m_inflight[i].stale = 1'b1;
            m_fetch_pc = {rpc[31:2], 2'b00};
        end else begin
            if (exp_dec_valid && drdy) void'(m_q.pop_front());
            if (do_rsp && !ent.stale) m_q.push_back(ent.addr);
            if (exp_req_valid && rdy) begin
                m_inflight.push_back('{addr: m_fetch_pc, stale: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%0b want=0", imem_req_valid); end
        checks++;
        if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got=%0b want=0", dec_valid); end
        checks++;
        if (dec_instr !== NOP) begin errors++; $display("FAIL reset_dec_instr got=%08h want=%08h", dec_instr, NOP); end
        checks++;
        if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc got=%08h want=0", dec_pc); end
        checks++;
        if (imem_req_addr !== RPC) begin errors++; $display("FAIL reset_addr got=%08h want=%08h", imem_req_addr, RPC); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got=%0b want=1", obs_req_valid); end
        checks++;
        if (obs_addr !== RPC) begin errors++; $display("FAIL first_req_addr got=%08h want=%08h", obs_addr, RPC); end
    endtask

    task automatic test_stream();
        int pops = 0;
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (obs_dec_valid && pops < 4) begin
                checks++;
                if (obs_dec_pc !== 32'(4 * pops)) begin errors++; $display("FAIL stream_pc got=%08h want=%08h", obs_dec_pc, 32'(4 * pops)); end
                checks++;
                if (obs_dec_instr !== mem_word(32'(4 * pops))) begin errors++; $display("FAIL stream_instr got=%08h want=%08h", obs_dec_instr, mem_word(32'(4 * pops))); end
                pops++;
            end
        end
        checks++;
        if (pops < 4) begin errors++; $display("FAIL stream_pops got=%0d want=4", pops); end
    endtask

    task automatic test_backpressure();
        int fires = 0;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            if (obs_req_valid) begin
                checks++;
                if (obs_addr !== 32'(4 * fires)) begin errors++; $display("FAIL bp_addr got=%08h want=%08h", obs_addr, 32'(4 * fires)); end
                fires++;
            end
        end
        checks++;
        if (fires !== DEPTH) begin errors++; $display("FAIL bp_fires got=%0d want=%0d", fires, DEPTH); end
        checks++;
        if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_blocked got=%0b want=0", obs_req_valid); end
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_req_valid !== 1'b1 || obs_addr !== 32'h10) begin
            errors++; $display("FAIL bp_resume got=%0b/%08h want=1/00000010", obs_req_valid, obs_addr);
        end
    endtask

    task automatic test_redirect();
        logic found = 1'b0;
        apply_reset();
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h103, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_valid got=%0b want=0", obs_req_valid); end
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got=%08h want=00000100", obs_addr); end
        for (int c = 0; c < 20 && !found; c++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (obs_dec_valid) begin
                found = 1'b1;
                checks++;
                if (obs_dec_pc !== 32'h100) begin errors++; $display("FAIL redir_first_pc got=%08h want=00000100", obs_dec_pc); end
                checks++;
                if (obs_dec_instr !== mem_word(32'h100)) begin errors++; $display("FAIL redir_first_instr got=%08h want=%08h", obs_dec_instr, mem_word(32'h100)); end
            end
        end
        if (!found) begin checks++; errors++; $display("FAIL redir_timeout got=no_dec_valid want=dec_valid"); end
    endtask

    task automatic test_redirect_pop_rsp();
        int fires = 0;
        apply_reset();
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        // Queue holds 0x0/0x4, 0x8 in flight: redirect, pop and response together.
        step(1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            if (c == 0) begin
                checks++;
                if (obs_dec_valid !== 1'b0) begin errors++; $display("FAIL rpr_dec_valid got=%0b want=0", obs_dec_valid); end
                checks++;
                if (obs_dec_instr !== NOP) begin errors++; $display("FAIL rpr_dec_instr got=%08h want=%08h", obs_dec_instr, NOP); end
            end
            if (obs_req_valid) begin
                checks++;
                if (obs_addr !== 32'h40 + 32'(4 * fires)) begin errors++; $display("FAIL rpr_addr got=%08h want=%08h", obs_addr, 32'h40 + 32'(4 * fires)); end
                fires++;
            end
        end
        // All old credits must be returned: a full DEPTH of new requests fit.
        checks++;
        if (fires !== DEPTH) begin errors++; $display("FAIL rpr_credits got=%0d want=%0d", fires, DEPTH); end
    endtask

    task automatic test_stall_and_async_reset();
        apply_reset();
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            checks++;
            if (obs_req_valid !== 1'b1 || obs_addr !== 32'h8) begin
                errors++; $display("FAIL stall_addr got=%0b/%08h want=1/00000008", obs_req_valid, obs_addr);
            end
        end
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs_addr !== 32'h8) begin errors++; $display("FAIL stall_release got=%08h want=00000008", obs_addr); end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_addr !== 32'hC) begin errors++; $display("FAIL stall_advance got=%08h want=0000000c", obs_addr); end
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (dec_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got=%0b want=1", dec_valid); end
        // Reset in the middle of the low phase, well away from any clock edge.
        #2;
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin
            errors++; $display("FAIL areset_valids got=%0b/%0b want=0/0", imem_req_valid, dec_valid);
        end
        checks++;
        if (dec_instr !== NOP || dec_pc !== 32'h0) begin
            errors++; $display("FAIL areset_dec got=%08h/%08h want=%08h/00000000", dec_instr, dec_pc, NOP);
        end
        checks++;
        if (imem_req_addr !== RPC) begin errors++; $display("FAIL areset_addr got=%08h want=%08h", imem_req_addr, RPC); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_req_valid !== 1'b1 || obs_addr !== RPC) begin
            errors++; $display("FAIL areset_restart got=%0b/%08h want=1/%08h", obs_req_valid, obs_addr, RPC);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_req_valid !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_pre got=%0b/%08h want=1/fffffffc", obs_req_valid, obs_addr);
        end
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_addr !== 32'h0) begin errors++; $display("FAIL wrap_post got=%08h want=00000000", obs_addr); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 500; c++) begin
            step(($urandom_range(0, 15) == 0),
                 32'($urandom_range(0, 1023)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1));
            checks++;
            if (obs_req_valid !== exp_req_valid) begin errors++; $display("FAIL rnd_req_valid cyc=%0d got=%0b want=%0b", c, obs_req_valid, exp_req_valid); end
            checks++;
            if (obs_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%08h want=%08h", c, obs_addr, exp_addr); end
            checks++;
            if (obs_dec_valid !== exp_dec_valid) begin errors++; $display("FAIL rnd_dec_valid cyc=%0d got=%0b want=%0b", c, obs_dec_valid, exp_dec_valid); end
            checks++;
            if (obs_dec_pc !== exp_dec_pc) begin errors++; $display("FAIL rnd_dec_pc cyc=%0d got=%08h want=%08h", c, obs_dec_pc, exp_dec_pc); end
            checks++;
            if (obs_dec_instr !== exp_dec_instr) begin errors++; $display("FAIL rnd_dec_instr cyc=%0d got=%08h want=%08h", c, obs_dec_instr, exp_dec_instr); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_pop_rsp();
        test_stall_and_async_reset();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
